// File: rtl/pcounter_pkg.sv
// Shared constants for the pcounter config slave: register map, CTRL/STAT bit
// positions, access kinds and register reset values.
package pcounter_pkg;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_LOAD  = 3'd1;
  localparam logic [2:0] REG_LIMIT = 3'd2;
  localparam logic [2:0] REG_STEP  = 3'd3;
  localparam logic [2:0] REG_STAT  = 3'd4;
  localparam logic [2:0] REG_COUNT = 3'd5;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_DOWN   = 1;
  localparam int CTRL_CLEAR  = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_WRAP = 0;
  localparam int STAT_RUN  = 1;

  // Truncated to the data width at the point of use, so LIMIT resets to all-ones.
  localparam logic [31:0] LIMIT_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] STEP_RST  = 32'd1;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2
  } acc_kind_t;

endpackage

// File: rtl/pcounter_cfg_slave_core.sv
// Programmable up/down wrap counter: clear > load > step, with a wrap strobe
// that is high in the cycle whose clock edge performs the wrap.
import pcounter_pkg::*;

module pcounter_core #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              run,
  input  logic              down,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] limit,
  output logic [DATA_W-1:0] count,
  output logic              wrap
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] count_next;
  logic              wrap_next;

  // Next-count arithmetic; the sum is one bit wider so overflow past LIMIT is seen.
  always_comb begin
    sum        = {1'b0, count} + {1'b0, step};
    count_next = count;
    wrap_next  = 1'b0;
    if (clear) begin
      count_next = {DATA_W{1'b0}};
    end else if (load) begin
      count_next = load_val;
    end else if (run && (step != {DATA_W{1'b0}})) begin
      if (!down) begin
        if (sum > {1'b0, limit}) begin
          count_next = {DATA_W{1'b0}};
          wrap_next  = 1'b1;
        end else begin
          count_next = sum[DATA_W-1:0];
        end
      end else begin
        if (count < step) begin
          count_next = limit;
          wrap_next  = 1'b1;
        end else begin
          count_next = count - step;
        end
      end
    end else begin
      count_next = count;
    end
  end

  assign wrap = wrap_next;

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {DATA_W{1'b0}};
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/pcounter_cfg_slave.sv
// Config-bus responder with register bank and read-back driving pcounter_core.
// Optional feature: define PCOUNTER_WRAP_IRQ_EN to add the irq_o output and CTRL[3].
import pcounter_pkg::*;

module pcounter_cfg_slave #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_enable,
  input  logic              cfg_rd_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              cfg_rvalid,
  output logic              cfg_err,
  output logic [DATA_W-1:0] counter_o
`ifdef PCOUNTER_WRAP_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  acc_kind_t         kind;
  logic              en_q;
  logic              is_wr;
  logic              wr_ctrl;
  logic              wr_load;
  logic              wr_limit;
  logic              wr_step;
  logic              wr_stat;
  logic              bad_slot;
  logic              ro_slot;
  logic              err_next;
  logic              clear_pulse;
  logic [DATA_W-1:0] rd_data;

  logic              run;
  logic              down;
  logic              irq_en;
  logic              wrap_sticky;
  logic              wrap;
  logic [DATA_W-1:0] limit;
  logic [DATA_W-1:0] step;

  // A held enable is one access: only its rising cycle counts.
  always_comb begin
    kind = ACC_NONE;
    if (cfg_enable && !en_q) begin
      kind = cfg_rd_wr ? ACC_RD : ACC_WR;
    end else begin
      kind = ACC_NONE;
    end
  end

  assign is_wr = (kind == ACC_WR);

  // Address decode: write strobes, slot legality and read-back data.
  always_comb begin
    wr_ctrl  = 1'b0;
    wr_load  = 1'b0;
    wr_limit = 1'b0;
    wr_step  = 1'b0;
    wr_stat  = 1'b0;
    bad_slot = 1'b0;
    ro_slot  = 1'b0;
    rd_data  = {DATA_W{1'b0}};
    case (cfg_addr)
      ADDR_W'(REG_CTRL): begin
        wr_ctrl               = is_wr;
        rd_data[CTRL_RUN]     = run;
        rd_data[CTRL_DOWN]    = down;
        rd_data[CTRL_IRQ_EN]  = irq_en;
      end
      ADDR_W'(REG_LOAD): begin
        wr_load = is_wr;
      end
      ADDR_W'(REG_LIMIT): begin
        wr_limit = is_wr;
        rd_data  = limit;
      end
      ADDR_W'(REG_STEP): begin
        wr_step = is_wr;
        rd_data = step;
      end
      ADDR_W'(REG_STAT): begin
        wr_stat             = is_wr;
        rd_data[STAT_WRAP]  = wrap_sticky;
        rd_data[STAT_RUN]   = run;
      end
      ADDR_W'(REG_COUNT): begin
        ro_slot = 1'b1;
        rd_data = counter_o;
      end
      default: begin
        bad_slot = 1'b1;
      end
    endcase
  end

  assign err_next    = (kind != ACC_NONE) && (bad_slot || (is_wr && ro_slot));
  assign clear_pulse = wr_ctrl && cfg_wdata[CTRL_CLEAR];

  // Bus-side registers: enable history and the registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      cfg_rdata  <= {DATA_W{1'b0}};
      cfg_rvalid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      en_q       <= cfg_enable;
      cfg_rvalid <= (kind == ACC_RD);
      cfg_err    <= err_next;
      if (kind == ACC_RD) begin
        cfg_rdata <= rd_data;
      end else begin
        cfg_rdata <= cfg_rdata;
      end
    end
  end

  // Register bank; a wrap in the same cycle as a STAT clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      run         <= 1'b0;
      down        <= 1'b0;
      limit       <= DATA_W'(LIMIT_RST);
      step        <= DATA_W'(STEP_RST);
      wrap_sticky <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        run  <= cfg_wdata[CTRL_RUN];
        down <= cfg_wdata[CTRL_DOWN];
      end
      if (wr_limit) begin
        limit <= cfg_wdata;
      end
      if (wr_step) begin
        step <= cfg_wdata;
      end
      if (wrap) begin
        wrap_sticky <= 1'b1;
      end else if (wr_stat && cfg_wdata[STAT_WRAP]) begin
        wrap_sticky <= 1'b0;
      end
    end
  end

`ifdef PCOUNTER_WRAP_IRQ_EN
  // Interrupt enable bit and the registered wrap interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en <= cfg_wdata[CTRL_IRQ_EN];
      end
      irq_o <= wrap_sticky & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  pcounter_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_pulse),
    .load     (wr_load),
    .load_val (cfg_wdata),
    .run      (run),
    .down     (down),
    .step     (step),
    .limit    (limit),
    .count    (counter_o),
    .wrap     (wrap)
  );

endmodule

// File: tb/tb_pcounter_cfg_slave.sv
// Directed self-checking bench for pcounter_cfg_slave (default or irq build).
module tb_pcounter_cfg_slave;

  logic       clk;
  logic       rst;
  logic       cfg_enable;
  logic       cfg_rd_wr;
  logic [2:0] cfg_addr;
  logic [9:0] cfg_wdata;
  logic [9:0] cfg_rdata;
  logic       cfg_rvalid;
  logic       cfg_err;
  logic [9:0] counter_o;
`ifdef PCOUNTER_WRAP_IRQ_EN
  logic       irq_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] rd_val;
  logic       rd_vld;
  logic       rd_err;

  pcounter_cfg_slave #(.DATA_W(10), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_enable (cfg_enable),
    .cfg_rd_wr  (cfg_rd_wr),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid),
    .cfg_err    (cfg_err),
    .counter_o  (counter_o)
`ifdef PCOUNTER_WRAP_IRQ_EN
    ,
    .irq_o      (irq_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_enable = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [9:0] d);
    cfg_enable = 1'b1; cfg_rd_wr = 1'b0; cfg_addr = a; cfg_wdata = d;
    cycle();
    cfg_enable = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    cfg_enable = 1'b1; cfg_rd_wr = 1'b1; cfg_addr = a; cfg_wdata = 10'd0;
    cycle();
    cfg_enable = 1'b0;
    rd_val = cfg_rdata; rd_vld = cfg_rvalid; rd_err = cfg_err;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (counter_o !== 10'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", counter_o); end
    n_tests++; if ({cfg_rvalid, cfg_err, cfg_rdata} !== 12'd0) begin n_fail++; $display("FAIL reset_outs: got rv=%b err=%b rdata=%0d expected all 0", cfg_rvalid, cfg_err, cfg_rdata); end
    bus_rd(3'd2);
    n_tests++; if (rd_val !== 10'd1023 || rd_vld !== 1'b1) begin n_fail++; $display("FAIL reset_limit: got %0d rv=%b expected 1023 rv=1", rd_val, rd_vld); end
    cycle(); bus_rd(3'd3);
    n_tests++; if (rd_val !== 10'd1) begin n_fail++; $display("FAIL reset_step: got %0d expected 1", rd_val); end
    cycle(); bus_rd(3'd0);
    n_tests++; if (rd_val !== 10'd0) begin n_fail++; $display("FAIL reset_ctrl: got %0d expected 0", rd_val); end
    cycle(); bus_rd(3'd4);
    n_tests++; if (rd_val !== 10'd0) begin n_fail++; $display("FAIL reset_stat: got %0d expected 0", rd_val); end
  endtask

  task automatic test_held_enable();
    do_reset();
    cfg_enable = 1'b1; cfg_rd_wr = 1'b0; cfg_addr = 3'd0; cfg_wdata = 10'd1;
    cycle();
    cfg_wdata = 10'd0;
    n_tests++; if (counter_o !== 10'd0) begin n_fail++; $display("FAIL held_c0: got %0d expected 0", counter_o); end
    cycle();
    cfg_enable = 1'b0;
    n_tests++; if (counter_o !== 10'd1) begin n_fail++; $display("FAIL held_c1: got %0d expected 1", counter_o); end
    cycle();
    n_tests++; if (counter_o !== 10'd2) begin n_fail++; $display("FAIL held_c2: got %0d expected 2", counter_o); end
    bus_rd(3'd0);
    n_tests++; if (rd_val !== 10'd1) begin n_fail++; $display("FAIL held_ctrl: got %0d expected 1", rd_val); end
  endtask

  task automatic test_up_wrap();
    do_reset();
    bus_wr(3'd2, 10'd3); cycle();
    bus_wr(3'd3, 10'd3); cycle();
    bus_wr(3'd0, 10'd1);
    n_tests++; if (counter_o !== 10'd0) begin n_fail++; $display("FAIL up_c0: got %0d expected 0", counter_o); end
    cycle();
    n_tests++; if (counter_o !== 10'd3) begin n_fail++; $display("FAIL up_c1: got %0d expected 3", counter_o); end
    cycle();
    n_tests++; if (counter_o !== 10'd0) begin n_fail++; $display("FAIL up_wrap: got %0d expected 0", counter_o); end
    bus_wr(3'd0, 10'd0);
    n_tests++; if (counter_o !== 10'd3) begin n_fail++; $display("FAIL up_stop: got %0d expected 3", counter_o); end
    cycle();
    n_tests++; if (counter_o !== 10'd3) begin n_fail++; $display("FAIL up_hold: got %0d expected 3", counter_o); end
    bus_rd(3'd4);
    n_tests++; if (rd_val !== 10'd1) begin n_fail++; $display("FAIL up_sticky: got %0d expected 1", rd_val); end
    cycle(); bus_wr(3'd4, 10'd1); cycle();
    bus_rd(3'd4);
    n_tests++; if (rd_val !== 10'd0) begin n_fail++; $display("FAIL up_w1c: got %0d expected 0", rd_val); end
  endtask

  task automatic test_down();
    do_reset();
    bus_wr(3'd1, 10'd1); cycle();
    bus_wr(3'd3, 10'd2); cycle();
    bus_wr(3'd0, 10'd3);
    n_tests++; if (counter_o !== 10'd1) begin n_fail++; $display("FAIL down_c0: got %0d expected 1", counter_o); end
    cycle();
    n_tests++; if (counter_o !== 10'd1023) begin n_fail++; $display("FAIL down_wrap: got %0d expected 1023", counter_o); end
    bus_rd(3'd5);
    n_tests++; if (rd_val !== 10'd1023 || rd_vld !== 1'b1 || rd_err !== 1'b0) begin n_fail++; $display("FAIL down_rdcount: got %0d rv=%b err=%b expected 1023 rv=1 err=0", rd_val, rd_vld, rd_err); end
    n_tests++; if (counter_o !== 10'd1021) begin n_fail++; $display("FAIL down_c2: got %0d expected 1021", counter_o); end
    cycle();
    n_tests++; if (cfg_rvalid !== 1'b0 || cfg_rdata !== 10'd1023) begin n_fail++; $display("FAIL down_rvhold: got rv=%b rdata=%0d expected rv=0 rdata=1023", cfg_rvalid, cfg_rdata); end
  endtask

  task automatic test_errors();
    do_reset();
    bus_wr(3'd1, 10'd7); cycle();
    bus_rd(3'd2);
    n_tests++; if (rd_val !== 10'd1023 || rd_err !== 1'b0) begin n_fail++; $display("FAIL err_rdlimit: got %0d err=%b expected 1023 err=0", rd_val, rd_err); end
    cycle(); bus_rd(3'd6);
    n_tests++; if (rd_val !== 10'd0 || rd_vld !== 1'b1 || rd_err !== 1'b1) begin n_fail++; $display("FAIL err_rd6: got %0d rv=%b err=%b expected 0 rv=1 err=1", rd_val, rd_vld, rd_err); end
    cycle();
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b expected 0", cfg_err); end
    bus_wr(3'd5, 10'd3);
    n_tests++; if (cfg_err !== 1'b1 || counter_o !== 10'd7) begin n_fail++; $display("FAIL err_wr5: got err=%b count=%0d expected err=1 count=7", cfg_err, counter_o); end
    cycle(); bus_rd(3'd5);
    n_tests++; if (rd_val !== 10'd7 || rd_err !== 1'b0) begin n_fail++; $display("FAIL err_count: got %0d err=%b expected 7 err=0", rd_val, rd_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_wr(3'd0, 10'd1);
    cycle();
    n_tests++; if (counter_o !== 10'd1) begin n_fail++; $display("FAIL b2b_run: got %0d expected 1", counter_o); end
    bus_wr(3'd1, 10'd5);
    n_tests++; if (counter_o !== 10'd5) begin n_fail++; $display("FAIL b2b_load: got %0d expected 5", counter_o); end
    cycle();
    n_tests++; if (counter_o !== 10'd6) begin n_fail++; $display("FAIL b2b_step: got %0d expected 6", counter_o); end
    bus_wr(3'd0, 10'd5);
    n_tests++; if (counter_o !== 10'd0) begin n_fail++; $display("FAIL b2b_clear: got %0d expected 0", counter_o); end
    cycle();
    n_tests++; if (counter_o !== 10'd1) begin n_fail++; $display("FAIL b2b_after: got %0d expected 1", counter_o); end
    bus_rd(3'd0);
    n_tests++; if (rd_val !== 10'd1) begin n_fail++; $display("FAIL b2b_ctrl: got %0d expected 1", rd_val); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus_wr(3'd0, 10'd1);
    cycle(); cycle(); cycle();
    n_tests++; if (counter_o !== 10'd3) begin n_fail++; $display("FAIL rst_pre: got %0d expected 3", counter_o); end
    bus_rd(3'd3);
    n_tests++; if (rd_val !== 10'd1 || counter_o !== 10'd4) begin n_fail++; $display("FAIL rst_prerd: got %0d count=%0d expected 1 count=4", rd_val, counter_o); end
    rst = 1'b1; cfg_enable = 1'b1; cfg_rd_wr = 1'b1; cfg_addr = 3'd2;
    cycle();
    n_tests++; if ({counter_o, cfg_rdata, cfg_rvalid, cfg_err} !== 22'd0) begin n_fail++; $display("FAIL rst_outs: got count=%0d rdata=%0d rv=%b err=%b expected all 0", counter_o, cfg_rdata, cfg_rvalid, cfg_err); end
    rst = 1'b0;
    cycle();
    n_tests++; if (cfg_rvalid !== 1'b1 || cfg_rdata !== 10'd1023 || counter_o !== 10'd0) begin n_fail++; $display("FAIL rst_reacc: got rv=%b rdata=%0d count=%0d expected rv=1 rdata=1023 count=0", cfg_rvalid, cfg_rdata, counter_o); end
    cycle();
    n_tests++; if (cfg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_heldone: got rv=%b expected 0", cfg_rvalid); end
    cfg_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_enable = 1'b0; cfg_rd_wr = 1'b0; cfg_addr = 3'd0; cfg_wdata = 10'd0;
    rd_val = 10'd0; rd_vld = 1'b0; rd_err = 1'b0;
    cycle();
    test_reset();
    test_held_enable();
    test_up_wrap();
    test_down();
    test_errors();
    test_back_to_back();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
